// File: rtl/loteria_emissor_aposta.sv
// Player-side bet sequencer: buffers a keypad ticket and replays it to the Loteria checker.
// Quick-pick tickets (LFSR-filled buffer on an empty confirm) are enabled by defining LOTERIA_SURPRESINHA_EN.
module loteria_emissor_aposta #(
    parameter int unsigned NUM_DIGITOS = 5,
    parameter int unsigned GAP         = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digito,
    input  logic       digito_valido,
    input  logic       apaga,
    input  logic       confirma,
    output logic [3:0] numero,
    output logic       insere,
    output logic       novo_jogo,
    output logic       fim_jogo,
    output logic       ocupado,
    output logic       erro,
    output logic [2:0] qtd_digitos,
    output logic [7:0] bilhetes
);
    // qtd is held one bit wider so a full 8-digit ticket stays distinguishable from empty.
    localparam int unsigned QW = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned GW = 4;
    localparam int unsigned DW = 4;
    localparam logic [QW-1:0] QTD_CHEIO = QW'(NUM_DIGITOS);
    localparam logic [IW-1:0] IDX_ULT   = IW'(NUM_DIGITOS - 1);
    localparam logic [GW-1:0] GAP_INI   = GW'(GAP);
    localparam logic [DW-1:0] MAX_DIG   = DW'(9);

    if (NUM_DIGITOS < 2 || NUM_DIGITOS > 8) begin : g_num_digitos_invalido
        $error("NUM_DIGITOS must be in 2..8");
    end
    if (GAP > 15) begin : g_gap_invalido
        $error("GAP must be in 0..15");
    end
    if (LFSR_SEED == 8'h00) begin : g_semente_invalida
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {COLETA, NOVO, ENVIA, FIM, ENCERRA} estado_t;

    estado_t         estado_q, estado_d;
    logic [DW-1:0]   digitos_q [NUM_DIGITOS];
    logic [DW-1:0]   digitos_d [NUM_DIGITOS];
    logic [QW-1:0]   qtd_q, qtd_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DW-1:0]   numero_q, numero_d;
    logic            insere_q, insere_d;
    logic            novo_q, novo_d;
    logic            fim_q, fim_d;
    logic            ocupado_q, ocupado_d;
    logic            erro_q, erro_d;
    logic [7:0]      bilhetes_q, bilhetes_d;

`ifdef LOTERIA_SURPRESINHA_EN
    logic [7:0]    lfsr_q;
    logic [DW-1:0] sorteio [NUM_DIGITOS];

    // Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_passo(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_passo(lfsr_q);
        end
    end

    // Quick-pick digits: low nibble of successive LFSR states folded into 0..9.
    always_comb begin : calc_sorteio
        logic [7:0] s;
        s = lfsr_q;
        for (int k = 0; k < int'(NUM_DIGITOS); k++) begin
            sorteio[k] = (s[3:0] > MAX_DIG) ? s[3:0] - DW'(10) : s[3:0];
            s = lfsr_passo(s);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= COLETA;
            qtd_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            numero_q   <= '0;
            insere_q   <= 1'b0;
            novo_q     <= 1'b0;
            fim_q      <= 1'b0;
            ocupado_q  <= 1'b0;
            erro_q     <= 1'b0;
            bilhetes_q <= '0;
            for (int k = 0; k < int'(NUM_DIGITOS); k++) begin
                digitos_q[k] <= '0;
            end
        end else begin
            estado_q   <= estado_d;
            qtd_q      <= qtd_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            numero_q   <= numero_d;
            insere_q   <= insere_d;
            novo_q     <= novo_d;
            fim_q      <= fim_d;
            ocupado_q  <= ocupado_d;
            erro_q     <= erro_d;
            bilhetes_q <= bilhetes_d;
            for (int k = 0; k < int'(NUM_DIGITOS); k++) begin
                digitos_q[k] <= digitos_d[k];
            end
        end
    end

    always_comb begin
        estado_d   = estado_q;
        digitos_d  = digitos_q;
        qtd_d      = qtd_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        numero_d   = numero_q;
        insere_d   = 1'b0;
        novo_d     = 1'b0;
        fim_d      = 1'b0;
        ocupado_d  = ocupado_q;
        erro_d     = 1'b0;
        bilhetes_d = bilhetes_q;

        unique case (estado_q)
            COLETA: begin
                // Digit handling first; confirma then looks at the pre-update count.
                if (apaga) begin
                    qtd_d = '0;
                end else if (digito_valido) begin
                    if (digito > MAX_DIG || qtd_q == QTD_CHEIO) begin
                        erro_d = 1'b1;
                    end else begin
                        digitos_d[qtd_q[IW-1:0]] = digito;
                        qtd_d = qtd_q + QW'(1);
                    end
                end
                if (confirma) begin
                    if (qtd_q == QTD_CHEIO) begin
                        estado_d  = NOVO;
                        ocupado_d = 1'b1;
`ifdef LOTERIA_SURPRESINHA_EN
                    end else if (qtd_q == '0) begin
                        digitos_d = sorteio;
                        qtd_d     = QTD_CHEIO;
                        estado_d  = NOVO;
                        ocupado_d = 1'b1;
`endif
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            NOVO: begin
                novo_d   = 1'b1;
                gap_d    = GAP_INI;
                idx_d    = '0;
                estado_d = ENVIA;
            end
            ENVIA: begin
                // Each strobe is followed by GAP idle cycles; numero holds through the gap.
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    insere_d = 1'b1;
                    numero_d = digitos_q[idx_q];
                    gap_d    = GAP_INI;
                    idx_d    = idx_q + IW'(1);
                    if (idx_q == IDX_ULT) begin
                        estado_d = FIM;
                    end
                end
            end
            FIM: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    fim_d    = 1'b1;
                    estado_d = ENCERRA;
                end
            end
            ENCERRA: begin
                numero_d  = '0;
                ocupado_d = 1'b0;
                qtd_d     = '0;
                if (bilhetes_q != 8'hFF) begin
                    bilhetes_d = bilhetes_q + 8'd1;
                end
                estado_d = COLETA;
            end
            default: estado_d = COLETA;
        endcase
    end

    assign numero      = numero_q;
    assign insere      = insere_q;
    assign novo_jogo   = novo_q;
    assign fim_jogo    = fim_q;
    assign ocupado     = ocupado_q;
    assign erro        = erro_q;
    assign qtd_digitos = qtd_q[2:0];
    assign bilhetes    = bilhetes_q;

endmodule
